// File: rtl/fu_alu_pkg.sv
// Shared types for the ALU functional unit: opcodes, writeback payload and the
// ROB age compare used by every flushable execute unit.
package fu_alu_pkg;

  localparam int unsigned ROB_W  = 5;
  localparam int unsigned PREG_W = 7;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSub   = 4'd1,
    AluAnd   = 4'd2,
    AluOr    = 4'd3,
    AluXor   = 4'd4,
    AluSll   = 4'd5,
    AluSrl   = 4'd6,
    AluSra   = 4'd7,
    AluSlt   = 4'd8,
    AluSltu  = 4'd9,
    AluLui   = 4'd10,
    AluPassb = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] pd;
    logic [31:0]       data;
  } fu_wb_t;

  // True when rob is strictly younger than tag; ages are taken relative to the
  // ROB head so the compare stays correct across index wrap-around.
  function automatic logic rob_is_younger(input logic [ROB_W-1:0] rob,
                                          input logic [ROB_W-1:0] tag,
                                          input logic [ROB_W-1:0] head);
    logic [ROB_W-1:0] age_rob;
    logic [ROB_W-1:0] age_tag;
    age_rob = rob - head;
    age_tag = tag - head;
    return age_rob > age_tag;
  endfunction

endpackage

// File: rtl/fu_result_buf.sv
// In-order result buffer with per-entry flush kill and compaction; entries
// always occupy a contiguous prefix so slot 0 is the head.
module fu_result_buf
  import fu_alu_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  fu_wb_t                     push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [ROB_W-1:0]           flush_tag_i,
  input  logic [ROB_W-1:0]           rob_head_i,
  output fu_wb_t                     head_o,
  output logic                       valid_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  fu_wb_t             mem_q [Depth];
  fu_wb_t             mem_d [Depth];
  logic [Depth-1:0]   vld_q, vld_d;
  logic [Depth-1:0]   kill;
  int unsigned        wr;

  always_comb begin
    kill = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      kill[i] = flush_i && vld_q[i] && rob_is_younger(mem_q[i].rob, flush_tag_i, rob_head_i);
    end
  end

  // A pop only ever removes slot 0; a killed head is dropped regardless of pop.
  always_comb begin
    vld_d = '0;
    wr    = 0;
    for (int unsigned j = 0; j < Depth; j++) begin
      mem_d[j] = '0;
    end
    for (int unsigned i = 0; i < Depth; i++) begin
      if (vld_q[i] && !kill[i] && !(i == 0 && pop_i)) begin
        for (int unsigned j = 0; j < Depth; j++) begin
          if (j == wr) begin
            mem_d[j] = mem_q[i];
            vld_d[j] = 1'b1;
          end
        end
        wr = wr + 1;
      end
    end
    if (push_i) begin
      for (int unsigned j = 0; j < Depth; j++) begin
        if (j == wr) begin
          mem_d[j] = push_data_i;
          vld_d[j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      vld_q <= vld_d;
      mem_q <= mem_d;
    end
  end

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      count_o = count_o + {{(CntW-1){1'b0}}, vld_q[i]};
    end
  end

  assign head_o  = mem_q[0];
  assign valid_o = vld_q[0];

endmodule

// File: rtl/fu_alu.sv
// Integer ALU functional unit: S1 captures the issued op, S2 computes with the
// PRF read data and pushes into the result buffer that drives writeback.
module fu_alu #(
  parameter int unsigned OUT_DEPTH = 2,
  parameter int unsigned ROB_W     = 5,
  parameter int unsigned PREG_W    = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue_valid,
  input  logic [3:0]        issue_op,
  input  logic              issue_use_imm,
  input  logic [31:0]       issue_imm,
  input  logic [PREG_W-1:0] issue_pd,
  input  logic [ROB_W-1:0]  issue_rob,
  input  logic [31:0]       ps1_data,
  input  logic [31:0]       ps2_data,
  input  logic [ROB_W-1:0]  rob_head,
  input  logic              mispredict,
  input  logic [ROB_W-1:0]  mispredict_tag,
  input  logic              wb_ready,
  output logic              fu_alu_ready,
  output logic              fu_alu_done,
  output logic [ROB_W-1:0]  rob_fu_alu,
  output logic [PREG_W-1:0] p_alu_out,
  output logic [31:0]       data_alu_out
);

  import fu_alu_pkg::*;

  localparam int unsigned CntW = $clog2(OUT_DEPTH + 1);

  logic              s1_valid_q, s1_valid_d;
  logic [3:0]        s1_op_q;
  logic              s1_use_imm_q;
  logic [31:0]       s1_imm_q;
  logic [PREG_W-1:0] s1_pd_q;
  logic [ROB_W-1:0]  s1_rob_q;

  logic              issue_kill, s1_kill, issue_accept;
  logic              push, pop;
  logic [31:0]       opb, result;
  logic [4:0]        shamt;
  fu_wb_t            push_data, head;
  logic              buf_valid;
  logic [CntW-1:0]   buf_count;
  int unsigned       in_flight;

  assign issue_kill   = mispredict && rob_is_younger(issue_rob, mispredict_tag, rob_head);
  assign s1_kill      = mispredict && rob_is_younger(s1_rob_q, mispredict_tag, rob_head);
  assign issue_accept = issue_valid && fu_alu_ready && !issue_kill;
  assign s1_valid_d   = issue_accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_use_imm_q <= 1'b0;
      s1_imm_q     <= '0;
      s1_pd_q      <= '0;
      s1_rob_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (issue_accept) begin
        s1_op_q      <= issue_op;
        s1_use_imm_q <= issue_use_imm;
        s1_imm_q     <= issue_imm;
        s1_pd_q      <= issue_pd;
        s1_rob_q     <= issue_rob;
      end
    end
  end

  assign opb   = s1_use_imm_q ? s1_imm_q : ps2_data;
  assign shamt = opb[4:0];

  always_comb begin
    result = '0;
    case (alu_op_e'(s1_op_q))
      AluAdd:   result = ps1_data + opb;
      AluSub:   result = ps1_data - opb;
      AluAnd:   result = ps1_data & opb;
      AluOr:    result = ps1_data | opb;
      AluXor:   result = ps1_data ^ opb;
      AluSll:   result = ps1_data << shamt;
      AluSrl:   result = ps1_data >> shamt;
      AluSra:   result = $signed(ps1_data) >>> shamt;
      AluSlt:   result = {31'b0, $signed(ps1_data) < $signed(opb)};
      AluSltu:  result = {31'b0, ps1_data < opb};
      AluLui:   result = s1_imm_q;
      AluPassb: result = opb;
      default:  result = '0;
    endcase
    // p0 is the hardwired zero register: complete the op but write nothing.
    if (s1_pd_q == '0) begin
      result = '0;
    end
  end

  assign push_data.rob  = s1_rob_q;
  assign push_data.pd   = s1_pd_q;
  assign push_data.data = result;
  assign push           = s1_valid_q && !s1_kill;
  assign pop            = buf_valid && wb_ready;

  fu_result_buf #(
    .Depth(OUT_DEPTH)
  ) u_result_buf (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .flush_i    (mispredict),
    .flush_tag_i(mispredict_tag),
    .rob_head_i (rob_head),
    .head_o     (head),
    .valid_o    (buf_valid),
    .count_o    (buf_count)
  );

  // Registers only: a same-cycle pop must not open a path from wb_ready.
  assign in_flight    = 32'(buf_count) + 32'(s1_valid_q);
  assign fu_alu_ready = in_flight < OUT_DEPTH;

  assign fu_alu_done  = buf_valid;
  assign rob_fu_alu   = head.rob;
  assign p_alu_out    = head.pd;
  assign data_alu_out = head.data;

  a_issue_when_ready: assert property (@(posedge clk) disable iff (!reset_n)
    issue_valid |-> fu_alu_ready)
    else $error("fu_alu: issue while not ready, op dropped");

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(s1_valid_q && 32'(buf_count) == OUT_DEPTH && !pop))
    else $error("fu_alu: result buffer full with S1 valid");

endmodule
